// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN pixel-stream front end.
package cnn_pkg;

  localparam int I_F_BW = 8;
  localparam int IX     = 28;
  localparam int IY     = 28;

  typedef logic [I_F_BW-1:0] pixel_t;

  // Streamer FSM encoding; ST_GAP is only reachable with CNN_STREAMER_ROW_GAP_EN.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STREAM = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_DONE   = 3'd3,
    ST_GAP    = 3'd4
  } streamer_state_e;

endpackage

// File: rtl/cnn_frame_ram.sv
// Frame RAM: one write port, one synchronous read port.
// The read register only updates on a read, so it holds the last pixel.
module cnn_frame_ram #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 784,
  parameter int ADDR_BW = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [ADDR_BW-1:0] wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               rd_en,
  input  logic [ADDR_BW-1:0] rd_addr,
  output logic [WIDTH-1:0]   rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; callers only present in-range addresses.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read; cleared by reset so the beat bus starts at zero.
  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cnn_fmap_streamer.sv
// Streams a stored CI-channel frame in raster order as valid/data beats.
// Optional build macro: CNN_STREAMER_ROW_GAP_EN inserts ROW_GAP idle
// cycles after every row except the last.
// Handshake: o_ot_valid marks a beat; there is no back-pressure, the sink
// must accept every valid beat. i_hold stalls reads (beats already in
// flight still emerge) and o_ot_fmap keeps its value while o_ot_valid=0.
module cnn_fmap_streamer
  import cnn_pkg::*;
#(
  parameter int I_F_BW  = cnn_pkg::I_F_BW,
  parameter int CI      = 1,
  parameter int IX      = cnn_pkg::IX,
  parameter int IY      = cnn_pkg::IY,
  parameter int ADDR_BW = 10,
  parameter int ROW_GAP = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_wr_en,
  input  logic [ADDR_BW-1:0]   i_wr_addr,
  input  logic [CI*I_F_BW-1:0] i_wr_data,
  input  logic                 i_start,
  input  logic                 i_hold,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_ot_valid,
  output logic [CI*I_F_BW-1:0] o_ot_fmap,
  output logic [2:0]           o_dbg_state
);

  localparam int DEPTH = IX * IY;
  localparam int COL_W = (IX > 1) ? $clog2(IX) : 1;
  localparam int ROW_W = (IY > 1) ? $clog2(IY) : 1;
  localparam logic [COL_W-1:0]   COL_LAST = COL_W'(IX - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST = ROW_W'(IY - 1);
  localparam logic [ADDR_BW:0]   DEPTH_L  = (ADDR_BW + 1)'(DEPTH);

  if ((2 ** ADDR_BW) < DEPTH) begin : g_bad_addr_bw
    $error("ADDR_BW too small for IX*IY");
  end
  if (ROW_GAP < 1) begin : g_bad_row_gap
    $error("ROW_GAP must be at least 1");
  end

  streamer_state_e    state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [ADDR_BW-1:0] addr_q, addr_d;
  logic               valid_q;
  logic               rd_en;
  logic               wr_ok;

`ifdef CNN_STREAMER_ROW_GAP_EN
  localparam int GAP_W = $clog2(ROW_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(ROW_GAP - 1);
  logic [GAP_W-1:0] gap_q, gap_d;
`endif

  assign o_busy      = (state_q == ST_STREAM) || (state_q == ST_DRAIN) || (state_q == ST_GAP);
  assign o_done      = (state_q == ST_DONE);
  assign o_ot_valid  = valid_q;
  assign o_dbg_state = state_q;

  // Loader writes only land while idle and inside the frame.
  assign wr_ok = i_wr_en && !o_busy && ({1'b0, i_wr_addr} < DEPTH_L);

  // Next-state and raster counter logic; addr tracks row*IX+col by counting.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    rd_en   = 1'b0;
`ifdef CNN_STREAMER_ROW_GAP_EN
    gap_d   = gap_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_STREAM;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
        end
      end
      ST_STREAM: begin
        if (!i_hold) begin
          rd_en  = 1'b1;
          addr_d = addr_q + 1'b1;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = ST_DRAIN;
            end else begin
              row_d = row_q + 1'b1;
`ifdef CNN_STREAMER_ROW_GAP_EN
              state_d = ST_GAP;
              gap_d   = '0;
`endif
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
`ifdef CNN_STREAMER_ROW_GAP_EN
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_STREAM;
        else                   gap_d   = gap_q + 1'b1;
      end
`endif
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, counters and beat-valid register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
`ifdef CNN_STREAMER_ROW_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      valid_q <= rd_en;
`ifdef CNN_STREAMER_ROW_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  cnn_frame_ram #(
    .WIDTH   (CI * I_F_BW),
    .DEPTH   (DEPTH),
    .ADDR_BW (ADDR_BW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok),
    .wr_addr (i_wr_addr),
    .wr_data (i_wr_data),
    .rd_en   (rd_en),
    .rd_addr (addr_q),
    .rd_data (o_ot_fmap)
  );

endmodule

// File: tb/tb_cnn_fmap_streamer.sv
// Bench for cnn_fmap_streamer: frame model + expected-beat queue.
module tb_cnn_fmap_streamer;
  import cnn_pkg::*;

  localparam int W          = 8;
  localparam int ADDR_BW    = 10;
  localparam int DEPTH      = IX * IY;
  localparam int ROW_GAP_TB = 2;
`ifdef CNN_STREAMER_ROW_GAP_EN
  localparam int GAP_CYC = (IY - 1) * ROW_GAP_TB;
`else
  localparam int GAP_CYC = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic               i_wr_en;
  logic [ADDR_BW-1:0] i_wr_addr;
  logic [W-1:0]       i_wr_data;
  logic               i_start;
  logic               i_hold;
  logic               o_busy;
  logic               o_done;
  logic               o_ot_valid;
  logic [W-1:0]       o_ot_fmap;
  logic [2:0]         o_dbg_state;

  cnn_fmap_streamer #(
    .I_F_BW (8), .CI (1), .IX (IX), .IY (IY),
    .ADDR_BW (ADDR_BW), .ROW_GAP (ROW_GAP_TB)
  ) dut (
    .clk (clk), .reset (reset),
    .i_wr_en (i_wr_en), .i_wr_addr (i_wr_addr), .i_wr_data (i_wr_data),
    .i_start (i_start), .i_hold (i_hold),
    .o_busy (o_busy), .o_done (o_done),
    .o_ot_valid (o_ot_valid), .o_ot_fmap (o_ot_fmap),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] mem_m [DEPTH];
  logic [W-1:0] exp_q [$];
  int tests = 0;
  int fails = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every valid beat pops one expected pixel.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && o_ot_valid) begin
        if (exp_q.size() == 0) chk("beat_unexpected", 32'(o_ot_fmap), 32'hFFFF_FFFF);
        else chk("beat_data", 32'(o_ot_fmap), 32'(exp_q.pop_front()));
      end
      if (!reset && o_done) chk("done_with_pending_beats", exp_q.size(), 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input int a, input logic [W-1:0] d);
    i_wr_en   = 1'b1;
    i_wr_addr = ADDR_BW'(a);
    i_wr_data = d;
    @(negedge clk);
    i_wr_en = 1'b0;
    if (a < DEPTH) mem_m[a] = d;
  endtask

  task automatic run_frame(input string tag, input int hold_after, input int hold_len,
                           input bit poke, input bit abort, input bit wr0);
    int beats, first_c, last_c, done_c, hold_left;
    logic busy_last, busy_done;
    logic [W-1:0] first_data;
    bit aborted;
    beats = 0; first_c = -1; last_c = -1; done_c = -1; hold_left = 0;
    busy_last = 1'b0; busy_done = 1'b1; first_data = '0; aborted = 1'b0;
    @(negedge clk);
    if (wr0) begin
      i_wr_en = 1'b1; i_wr_addr = '0; i_wr_data = 8'h7F;
      mem_m[0] = 8'h7F;
    end
    i_start = 1'b1;
    for (int a = 0; a < DEPTH; a++) exp_q.push_back(mem_m[a]);
    @(negedge clk);
    i_start = 1'b0; i_wr_en = 1'b0;
    chk({tag, "_busy_rise"}, 32'(o_busy), 1);
    for (int cyc = 1; cyc < 4000 && done_c < 0 && !aborted; cyc++) begin
      @(negedge clk);
      i_start = 1'b0; i_wr_en = 1'b0;
      if (o_ot_valid) begin
        if (first_c < 0) begin first_c = cyc; first_data = o_ot_fmap; end
        beats++;
        last_c = cyc;
        busy_last = o_busy;
      end
      if (o_done) begin done_c = cyc; busy_done = o_busy; end
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) i_hold = 1'b0;
      end
      if (o_ot_valid && hold_len > 0 && beats == hold_after + 1) begin
        i_hold = 1'b1; hold_left = hold_len;
      end
      if (o_ot_valid && poke && beats == 101) begin
        i_start = 1'b1; i_wr_en = 1'b1; i_wr_addr = 10'd5; i_wr_data = 8'hAA;
      end
      if (o_ot_valid && abort && beats == 301) begin
        reset = 1'b1; aborted = 1'b1;
      end
    end
    i_hold = 1'b0;
    if (aborted) begin
      @(negedge clk);
      chk({tag, "_abort_valid"}, 32'(o_ot_valid), 0);
      chk({tag, "_abort_busy"}, 32'(o_busy), 0);
      chk({tag, "_abort_done"}, 32'(o_done), 0);
      reset = 1'b0;
      exp_q.delete();
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        chk({tag, "_abort_quiet"}, {30'd0, o_done, o_ot_valid}, 0);
      end
      return;
    end
    chk({tag, "_done_seen"}, 32'(done_c >= 0), 1);
    chk({tag, "_beats"}, beats, DEPTH);
    chk({tag, "_first_latency"}, first_c, 1);
    chk({tag, "_span"}, last_c - first_c + 1, DEPTH + hold_len + GAP_CYC);
    chk({tag, "_done_after_last"}, done_c, last_c + 1);
    chk({tag, "_busy_at_last"}, 32'(busy_last), 1);
    chk({tag, "_busy_at_done"}, 32'(busy_done), 0);
    if (wr0) chk({tag, "_first_beat"}, 32'(first_data), 32'h7F);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    i_start = 1'b0; i_hold = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(o_ot_valid), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_fmap", 32'(o_ot_fmap), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int a = 0; a < DEPTH; a++) wr(a, W'(a % 256));
    for (int k = 0; k < 4; k++) wr($urandom_range(DEPTH, 1023), W'($urandom));

    run_frame("ramp", 0, 0, 1'b0, 1'b0, 1'b0);
    run_frame("hold", 40, 3, 1'b1, 1'b0, 1'b0);
    run_frame("abort", 0, 0, 1'b0, 1'b1, 1'b0);
    run_frame("after_abort", 0, 0, 1'b0, 1'b0, 1'b0);

    for (int a = 0; a < DEPTH; a++) wr(a, W'($urandom));
    run_frame("rand_wr0", $urandom_range(0, IY - 2) * IX + $urandom_range(2, 20),
              $urandom_range(1, 5), 1'b0, 1'b0, 1'b1);
    run_frame("rand_hold", $urandom_range(0, IY - 2) * IX + $urandom_range(2, 20),
              $urandom_range(1, 5), 1'b1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("end_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
